// File: rtl/taxi_axil_rd_timeout_if.sv
// AXI4-lite read-channel bundle (AR + R) with master/slave views.
interface taxi_axil_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ARUSER_EN = 0,
  parameter int ARUSER_W  = 1,
  parameter int RUSER_EN  = 0,
  parameter int RUSER_W   = 1
) ();
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic [RUSER_W-1:0]  ruser;
  logic                rvalid;
  logic                rready;

  modport rd_mst (
    output araddr, arprot, aruser, arvalid, rready,
    input  arready, rdata, rresp, ruser, rvalid
  );

  modport rd_slv (
    input  araddr, arprot, aruser, arvalid, rready,
    output arready, rdata, rresp, ruser, rvalid
  );
endinterface

// File: rtl/taxi_axil_rd_timeout.sv
// AXI4-lite read watchdog: one read in flight, 4-cycle round trip with a zero-wait slave.
// Forces ERR_RESP upstream after TIMEOUT_CYCLES, then drains the late downstream read; all outputs registered.
module taxi_axil_rd_timeout #(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [1:0] ERR_RESP       = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  taxi_axil_if.rd_slv s_axil_rd,
  taxi_axil_if.rd_mst m_axil_rd,
  output logic        stat_timeout
);

  localparam int DATA_W    = s_axil_rd.DATA_W;
  localparam int ADDR_W    = s_axil_rd.ADDR_W;
  localparam int ARUSER_EN = s_axil_rd.ARUSER_EN;
  localparam int ARUSER_W  = s_axil_rd.ARUSER_W;
  localparam int RUSER_EN  = s_axil_rd.RUSER_EN;
  localparam int RUSER_W   = s_axil_rd.RUSER_W;
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, RESP, OUT, ERR, DRAIN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                ar_done;
  logic                m_done;
  logic                s_arready_reg;
  logic                s_rvalid_reg;
  logic                m_arvalid_reg;
  logic                m_rready_reg;
  logic                stat_timeout_reg;
  logic [ADDR_W-1:0]   araddr_reg;
  logic [2:0]          arprot_reg;
  logic [ARUSER_W-1:0] aruser_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [1:0]          rresp_reg;
  logic [RUSER_W-1:0]  ruser_reg;

  logic cnt_last;
  logic m_r_hs;

  assign cnt_last = (cnt == CNT_LAST);
  assign m_r_hs   = m_rready_reg && m_axil_rd.rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      ar_done          <= 1'b0;
      m_done           <= 1'b0;
      s_arready_reg    <= 1'b0;
      s_rvalid_reg     <= 1'b0;
      m_arvalid_reg    <= 1'b0;
      m_rready_reg     <= 1'b0;
      stat_timeout_reg <= 1'b0;
    end else begin
      stat_timeout_reg <= 1'b0;
      unique case (state)
        IDLE: begin
          s_arready_reg <= 1'b1;
          if (s_arready_reg && s_axil_rd.arvalid) begin
            araddr_reg    <= s_axil_rd.araddr;
            arprot_reg    <= s_axil_rd.arprot;
            aruser_reg    <= s_axil_rd.aruser;
            cnt           <= '0;
            ar_done       <= 1'b0;
            m_done        <= 1'b0;
            s_arready_reg <= 1'b0;
            m_arvalid_reg <= 1'b1;
            state         <= ADDR;
          end
        end
        ADDR: begin
          // An AR accepted on the timeout cycle still counts; only the R phase is left to drain.
          if (m_axil_rd.arready) begin
            ar_done       <= 1'b1;
            m_arvalid_reg <= 1'b0;
            m_rready_reg  <= 1'b1;
          end
          if (cnt_last) begin
            state            <= ERR;
            stat_timeout_reg <= 1'b1;
            s_rvalid_reg     <= 1'b1;
            rdata_reg        <= '0;
            rresp_reg        <= ERR_RESP;
            ruser_reg        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (m_axil_rd.arready) begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          // A real response on the timeout cycle takes priority over the error.
          if (m_axil_rd.rvalid) begin
            rdata_reg    <= m_axil_rd.rdata;
            rresp_reg    <= m_axil_rd.rresp;
            ruser_reg    <= m_axil_rd.ruser;
            m_rready_reg <= 1'b0;
            s_rvalid_reg <= 1'b1;
            state        <= OUT;
          end else if (cnt_last) begin
            state            <= ERR;
            stat_timeout_reg <= 1'b1;
            s_rvalid_reg     <= 1'b1;
            rdata_reg        <= '0;
            rresp_reg        <= ERR_RESP;
            ruser_reg        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OUT: begin
          if (s_axil_rd.rready) begin
            s_rvalid_reg  <= 1'b0;
            s_arready_reg <= 1'b1;
            state         <= IDLE;
          end
        end
        ERR, DRAIN: begin
          if (!ar_done && m_axil_rd.arready) begin
            ar_done       <= 1'b1;
            m_arvalid_reg <= 1'b0;
            m_rready_reg  <= 1'b1;
          end
          if (m_r_hs) begin
            m_done       <= 1'b1;
            m_rready_reg <= 1'b0;
          end
          if (state == ERR) begin
            if (s_axil_rd.rready) begin
              s_rvalid_reg <= 1'b0;
              if (m_done || m_r_hs) begin
                s_arready_reg <= 1'b1;
                state         <= IDLE;
              end else begin
                state <= DRAIN;
              end
            end
          end else if (m_r_hs) begin
            s_arready_reg <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_axil_rd.arready = s_arready_reg;
  assign s_axil_rd.rvalid  = s_rvalid_reg;
  assign s_axil_rd.rdata   = rdata_reg;
  assign s_axil_rd.rresp   = rresp_reg;
  assign s_axil_rd.ruser   = (RUSER_EN != 0) ? ruser_reg : '0;

  assign m_axil_rd.arvalid = m_arvalid_reg;
  assign m_axil_rd.araddr  = araddr_reg;
  assign m_axil_rd.arprot  = arprot_reg;
  assign m_axil_rd.aruser  = (ARUSER_EN != 0) ? aruser_reg : '0;
  assign m_axil_rd.rready  = m_rready_reg;

  assign stat_timeout = stat_timeout_reg;

endmodule

// File: tb/tb_taxi_axil_rd_timeout.sv
// Directed + randomized bench for taxi_axil_rd_timeout with an upstream response scoreboard.
module tb_taxi_axil_rd_timeout;
  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  user;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stat_timeout;
  int   tests = 0;
  int   fails = 0;
  int   to_cnt = 0;
  rsp_t sb_q[$];

  taxi_axil_if #(.DATA_W(32), .ADDR_W(16), .ARUSER_EN(1), .ARUSER_W(4),
                 .RUSER_EN(1), .RUSER_W(4)) s_if ();
  taxi_axil_if #(.DATA_W(32), .ADDR_W(16), .ARUSER_EN(1), .ARUSER_W(4),
                 .RUSER_EN(1), .RUSER_W(4)) m_if ();

  taxi_axil_rd_timeout #(.TIMEOUT_CYCLES(TO), .ERR_RESP(2'b10)) dut (
    .clk(clk),
    .rst(rst),
    .s_axil_rd(s_if),
    .m_axil_rd(m_if),
    .stat_timeout(stat_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && stat_timeout) to_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    rsp_t e;
    e = '0;
    chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    chk(tag, {s_if.rdata, s_if.rresp, s_if.ruser}, {e.data, e.resp, e.user});
  endtask

  // One complete read with a well-behaved slave; stalls stay below the timeout.
  task automatic do_read(input logic [15:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input int ar_wait, input int r_wait, input int rr_wait);
    int n;
    logic [3:0] user;
    user = addr[7:4];
    sb_q.push_back('{data, resp, user});
    n = 0;
    while (!s_if.arready && n < 50) begin tick(); n++; end
    chk("s_arready_wait", s_if.arready, 1);
    s_if.araddr  = addr;
    s_if.arprot  = addr[2:0];
    s_if.aruser  = ~addr[3:0];
    s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    chk("m_arvalid", m_if.arvalid, 1);
    chk("m_ar_payload", {m_if.araddr, m_if.arprot, m_if.aruser}, {addr, addr[2:0], ~addr[3:0]});
    repeat (ar_wait) tick();
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    chk("m_rready", {m_if.rready, m_if.arvalid}, 2'b10);
    repeat (r_wait) tick();
    m_if.rdata  = data;
    m_if.rresp  = resp;
    m_if.ruser  = user;
    m_if.rvalid = 1'b1;
    tick();
    m_if.rvalid = 1'b0;
    m_if.rdata  = 32'h0;
    chk("s_rvalid", s_if.rvalid, 1);
    repeat (rr_wait) begin
      tick();
      chk("s_rvalid_hold", s_if.rvalid, 1);
    end
    s_if.rready = 1'b1;
    sb_check("s_rdata");
    tick();
    s_if.rready = 1'b0;
    chk("s_rvalid_clear", s_if.rvalid, 0);
  endtask

  initial begin
    s_if.araddr = '0; s_if.arprot = '0; s_if.aruser = '0; s_if.arvalid = 1'b0; s_if.rready = 1'b0;
    m_if.arready = 1'b0; m_if.rdata = '0; m_if.rresp = '0; m_if.ruser = '0; m_if.rvalid = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_outputs", {s_if.arready, s_if.rvalid, m_if.arvalid, m_if.rready, stat_timeout}, 5'b0);
    rst = 1'b0;
    tick();
    chk("rst_release_arready", s_if.arready, 1);

    // Zero-wait slave, 0x100 -> DEADBEEF/OKAY
    do_read(16'h0100, 32'hDEADBEEF, 2'b00, 0, 0, 0);
    chk("zw_no_timeout", to_cnt, 0);

    // Slave never accepts AR: error after TO cycles, then late AR/R drained
    sb_q.push_back('{32'h0, 2'b10, 4'h0});
    s_if.araddr = 16'h0200; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    repeat (TO - 1) tick();
    chk("ar_to_pre", {s_if.rvalid, stat_timeout}, 2'b00);
    tick();
    chk("ar_to_fire", {s_if.rvalid, stat_timeout, m_if.arvalid}, 3'b111);
    tick();
    chk("ar_to_pulse", {stat_timeout, m_if.arvalid, m_if.rready}, 3'b010);
    s_if.rready = 1'b1;
    sb_check("ar_to_err");
    tick();
    s_if.rready = 1'b0;
    chk("ar_drain", {s_if.rvalid, s_if.arready, m_if.arvalid}, 3'b001);
    repeat (3) tick();
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    chk("ar_drain_r", {m_if.rready, m_if.arvalid, s_if.arready, s_if.rvalid}, 4'b1000);
    m_if.rvalid = 1'b1; m_if.rdata = 32'h1111_1111;
    tick();
    m_if.rvalid = 1'b0;
    chk("ar_drain_done", {s_if.arready, s_if.rvalid, m_if.rready}, 3'b100);
    chk("ar_to_count", to_cnt, 1);
    do_read(16'h0204, 32'hCAFE0001, 2'b00, 1, 2, 0);

    // R exactly on the timeout cycle: real data wins
    do_read(16'h0300, 32'h0BADF00D, 2'b00, 0, TO - 2, 0);
    chk("edge_no_timeout", to_cnt, 1);

    // R 40 cycles late, upstream stalls 10 cycles on the error
    sb_q.push_back('{32'h0, 2'b10, 4'h0});
    s_if.araddr = 16'h0400; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    repeat (TO - 1) tick();
    chk("late_err", {s_if.rvalid, stat_timeout}, 2'b11);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("late_err_hold", {s_if.rvalid, s_if.rdata, s_if.rresp, s_if.ruser}, {1'b1, 32'h0, 2'b10, 4'h0});
    end
    s_if.rready = 1'b1;
    sb_check("late_err_data");
    tick();
    s_if.rready = 1'b0;
    chk("late_drain", {s_if.rvalid, s_if.arready, m_if.rready}, 3'b001);
    repeat (12) tick();
    chk("late_drain_hold", {s_if.rvalid, s_if.arready, m_if.rready}, 3'b001);
    m_if.rvalid = 1'b1; m_if.rdata = 32'h2222_2222;
    tick();
    m_if.rvalid = 1'b0;
    chk("late_done", {s_if.arready, s_if.rvalid, m_if.rready}, 3'b100);
    chk("late_to_count", to_cnt, 2);

    // In ERR, late R and upstream rready on the same cycle go straight to IDLE
    sb_q.push_back('{32'h0, 2'b10, 4'h0});
    s_if.araddr = 16'h0500; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    repeat (TO - 1) tick();
    chk("both_err", s_if.rvalid, 1);
    s_if.rready = 1'b1; m_if.rvalid = 1'b1;
    sb_check("both_err_data");
    tick();
    s_if.rready = 1'b0; m_if.rvalid = 1'b0;
    chk("both_idle", {s_if.arready, s_if.rvalid, m_if.rready}, 3'b100);

    // Random back-to-back reads with stalls below the timeout
    for (int i = 0; i < 100; i++) begin
      do_read(16'($urandom), $urandom, 2'($urandom_range(0, 3)),
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
    end
    chk("rand_no_timeout", to_cnt, 3);

    // Reset while in RESP, then a clean read
    s_if.araddr = 16'h0600; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    chk("rst_resp_state", m_if.rready, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_valids", {s_if.arready, s_if.rvalid, m_if.arvalid, m_if.rready}, 4'b0);
    rst = 1'b0;
    tick();
    do_read(16'h0604, 32'h600D_0604, 2'b00, 2, 3, 1);

    chk("final_to_count", to_cnt, 3);
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
